rgb_to_grayscale_unit: RTL and testbench
========================================

// Module: rgb_to_grayscale_unit
// PURPOSE
//   Streaming pixel converter between the camera/BMP pixel source and the
//   grayscale store (store_grayscale). Takes one 24-bit RGB pixel per clock
//   when valid and emits its 8-bit luma. Output is a 2-stage pipeline.
//   store_grayscale is a separate downstream consumer: it writes each luma
//   byte three times (B,G,R) at incrementing byte addresses.
// PARAMETERS
//   DW    8    width of each colour channel and of the luma output
//   W_R   77   red weight, Q0.8 (0.299*256)
//   W_G   150  green weight, Q0.8 (0.587*256)
//   W_B   29   blue weight, Q0.8 (0.114*256)
//   Constraint: W_R+W_G+W_B == 256. Checked at elaboration; violation is an
//   elaboration error.
// PORTS
//   clk          in   1   single clock; all state updates on rising edge
//   rst          in   1   asynchronous, active-low reset (0 = in reset)
//   red_i        in   DW  red channel of the current pixel
//   green_i      in   DW  green channel of the current pixel
//   blue_i       in   DW  blue channel of the current pixel
//   cam_done_i   in   1   pixel-valid qualifier; RGB sampled when 1
//   grayscale_o  out  DW  luma of the pixel accepted 2 cycles earlier
//   done_o       out  1   high for exactly the cycles grayscale_o is new
// BEHAVIOUR
//   - Reset (rst==0, async assert; release synchronised by the caller):
//     all pipeline registers, grayscale_o and done_o are 0 immediately.
//   - Formula: Y = (W_R*R + W_G*G + W_B*B + 128) >> 8. Unsigned arithmetic;
//     the 16-bit accumulator cannot overflow (max 65408). No saturation needed.
//     Grey input (R==G==B) maps exactly to itself.
//   - Stage 1 (edge k): if cam_done_i, register the three products and v1=1;
//     else v1=0 and products hold.
//   - Stage 2 (edge k+1): if v1, grayscale_o <= rounded sum >> 8 and done_o
//     <= 1; else done_o <= 0 and grayscale_o holds its last value.
//   - Latency: a pixel presented with cam_done_i=1 before edge k appears on
//     grayscale_o/done_o after edge k+1, i.e. exactly 2 cycles.
//   - Throughput: 1 pixel/clock, no backpressure. Pixels with cam_done_i=0
//     are dropped. Gaps propagate 1:1 to done_o.
//   - Reset mid-stream: in-flight pixels are discarded. After release, the
//     first valid pixel again takes 2 cycles.
//   - X on RGB while cam_done_i==0 never reaches grayscale_o.
// STRUCTURE
//   - Shared package gray_pkg: DW, default weights W_R/W_G/W_B, rounding
//     constant ROUND=128, typedef rgb_t (packed struct {r,g,b}) and luma_t.
//     Used by this block and by store_grayscale.
//   - One natural sub-module: gray_weight_mac (3 multipliers + adder, with
//     stage-1 registers). The top adds the valid pipeline and output
//     registers.
// TESTING
//   1. Hold rst=0 with random RGB and cam_done_i=1 -> done_o=0 and
//      grayscale_o=0 throughout.
//   2. One valid pixel at a time, 2-cycle latency:
//      - (255,255,255) -> 255; (0,0,0) -> 0; (100,100,100) -> 100.
//      - done_o is a single-cycle pulse on each.
//   3. Single-channel pixels -> per-channel weights:
//      - (255,0,0) -> 77
//      - (0,255,0) -> 149
//      - (0,0,255) -> 29
//   4. Valid pattern 1,1,0,1 on consecutive cycles -> done_o 1,1,0,1 delayed
//      2 cycles. grayscale_o holds its value during the gap cycle.
//   5. Drop rst to 0 while two pixels are in flight -> both lost and outputs
//      0 at once. First post-release pixel is emitted after 2 cycles.
//   6. Stream 128x128 = 16384 random pixels back-to-back, with
//      store_grayscale attached:
//      - exactly 16384 done_o pulses, each matching the integer reference model;
//      - store holds 49152 bytes, each luma written 3 times.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the RGB-to-luma path and the downstream grayscale store.
// Weights are Q0.8 BT.601 luma coefficients and must sum to exactly 256.
package gray_pkg;
    localparam int DW    = 8;
    localparam int W_R   = 77;
    localparam int W_G   = 150;
    localparam int W_B   = 29;
    localparam int ROUND = 128;

    typedef logic [DW-1:0] luma_t;

    typedef struct packed {
        luma_t r;
        luma_t g;
        luma_t b;
    } rgb_t;
endpackage

// File: rtl/gray_weight_mac.sv
// Stage-1 weighted products of one RGB pixel, followed by the rounding adder.
// Products are only loaded on a valid pixel, so junk on idle cycles never enters.
module gray_weight_mac
    import gray_pkg::*;
#(
    parameter int W_R = gray_pkg::W_R,
    parameter int W_G = gray_pkg::W_G,
    parameter int W_B = gray_pkg::W_B
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  rgb_t  pixel,
    output luma_t luma
);
    // A 9-bit weight covers the degenerate case of a single weight equal to 256.
    localparam int PW = DW + 9;
    localparam int SW = DW + 11;

    logic [PW-1:0] prod_r;
    logic [PW-1:0] prod_g;
    logic [PW-1:0] prod_b;
    logic [SW-1:0] sum;
    logic          unused_sum_bits;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_r <= '0;
            prod_g <= '0;
            prod_b <= '0;
        end else if (load) begin
            prod_r <= PW'(pixel.r) * PW'(W_R);
            prod_g <= PW'(pixel.g) * PW'(W_G);
            prod_b <= PW'(pixel.b) * PW'(W_B);
        end
    end

    // With weights summing to 256 the rounded total stays below 2^(DW+8).
    assign sum  = SW'(prod_r) + SW'(prod_g) + SW'(prod_b) + SW'(ROUND);
    assign luma = sum[DW+7:8];

    assign unused_sum_bits = ^{sum[SW-1:DW+8], sum[7:0]};
endmodule

// File: rtl/rgb_to_grayscale_unit.sv
// Two-stage streaming RGB-to-luma converter: one pixel per clock, no backpressure.
// cam_done_i qualifies the pixel (there is no ready); done_o flags a new grayscale_o.
module rgb_to_grayscale_unit
    import gray_pkg::*;
#(
    parameter int DW  = gray_pkg::DW,
    parameter int W_R = gray_pkg::W_R,
    parameter int W_G = gray_pkg::W_G,
    parameter int W_B = gray_pkg::W_B
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] red_i,
    input  logic [DW-1:0] green_i,
    input  logic [DW-1:0] blue_i,
    input  logic          cam_done_i,
    output logic [DW-1:0] grayscale_o,
    output logic          done_o
);
    if (W_R + W_G + W_B != 256) begin : g_bad_weights
        $error("rgb_to_grayscale_unit: W_R + W_G + W_B must equal 256");
    end
    if (DW != gray_pkg::DW) begin : g_bad_width
        $error("rgb_to_grayscale_unit: DW must match gray_pkg::DW");
    end

    rgb_t  pixel;
    luma_t mac_luma;
    logic  v1;

    assign pixel = '{r: red_i, g: green_i, b: blue_i};

    gray_weight_mac #(
        .W_R (W_R),
        .W_G (W_G),
        .W_B (W_B)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .load  (cam_done_i),
        .pixel (pixel),
        .luma  (mac_luma)
    );

    // grayscale_o holds through gaps; only done_o tells the consumer it is new.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1          <= 1'b0;
            done_o      <= 1'b0;
            grayscale_o <= '0;
        end else begin
            v1     <= cam_done_i;
            done_o <= v1;
            if (v1) begin
                grayscale_o <= mac_luma;
            end
        end
    end
endmodule

// File: tb/tb_rgb_to_grayscale_unit.sv
// Self-checking bench for rgb_to_grayscale_unit with a behavioural luma model
// and a behavioural grayscale store that writes each luma byte three times.
module tb_rgb_to_grayscale_unit;
    localparam int NPIX  = 128 * 128;
    localparam int NBYTE = 3 * NPIX;

    logic       clk;
    logic       rst;
    logic [7:0] red_i;
    logic [7:0] green_i;
    logic [7:0] blue_i;
    logic       cam_done_i;
    logic [7:0] grayscale_o;
    logic       done_o;

    int n_checks;
    int n_fail;

    // reference model state: pixel accepted last cycle and expected outputs now
    logic       pend_v;
    logic [7:0] pend_y;
    logic       exp_done;
    logic [7:0] exp_gray;

    logic [7:0] exp_q[$];
    logic [7:0] exp_all[NPIX];
    logic [7:0] store_mem[NBYTE];
    int         store_addr;

    rgb_to_grayscale_unit dut (
        .clk         (clk),
        .rst         (rst),
        .red_i       (red_i),
        .green_i     (green_i),
        .blue_i      (blue_i),
        .cam_done_i  (cam_done_i),
        .grayscale_o (grayscale_o),
        .done_o      (done_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] ref_luma(input int r, input int g, input int b);
        int y;
        y = (77 * r + 150 * g + 29 * b + 128) / 256;
        return 8'(y);
    endfunction

    task automatic model_reset();
        pend_v   = 1'b0;
        pend_y   = 8'd0;
        exp_done = 1'b0;
        exp_gray = 8'd0;
    endtask

    // driver: present a pixel, clock once, then advance the model
    task automatic drive_cycle(input logic v, input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b);
        red_i      = r;
        green_i    = g;
        blue_i     = b;
        cam_done_i = v;
        @(posedge clk);
        #1;
        exp_done = pend_v;
        if (pend_v) exp_gray = pend_y;
        pend_v = v;
        pend_y = ref_luma(int'(r), int'(g), int'(b));
    endtask

    task automatic drive_idle();
        drive_cycle(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            red_i      = 8'($urandom);
            green_i    = 8'($urandom);
            blue_i     = 8'($urandom);
            cam_done_i = 1'b1;
            @(posedge clk);
            #1;
            n_checks++;
            if (done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_done: got %b expected 0", done_o);
            end
            n_checks++;
            if (grayscale_o !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_gray: got %0d expected 0", grayscale_o);
            end
        end
        cam_done_i = 1'b0;
        rst        = 1'b1;
    endtask

    task automatic test_single_pixels();
        logic [7:0] tr[6] = '{8'd255, 8'd0, 8'd100, 8'd255, 8'd0,   8'd0};
        logic [7:0] tg[6] = '{8'd255, 8'd0, 8'd100, 8'd0,   8'd255, 8'd0};
        logic [7:0] tb[6] = '{8'd255, 8'd0, 8'd100, 8'd0,   8'd0,   8'd255};
        logic [7:0] ty[6] = '{8'd255, 8'd0, 8'd100, 8'd77,  8'd149, 8'd29};
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, tr[i], tg[i], tb[i]);
            n_checks++;
            if (done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL single_early[%0d]: done got %b expected 0", i, done_o);
            end
            drive_idle();
            n_checks++;
            if (done_o !== 1'b1 || grayscale_o !== ty[i]) begin
                n_fail++;
                $display("FAIL single_out[%0d]: got done=%b y=%0d expected done=1 y=%0d",
                         i, done_o, grayscale_o, ty[i]);
            end
            drive_idle();
            n_checks++;
            if (done_o !== 1'b0 || grayscale_o !== ty[i]) begin
                n_fail++;
                $display("FAIL single_pulse[%0d]: got done=%b y=%0d expected done=0 y=%0d",
                         i, done_o, grayscale_o, ty[i]);
            end
        end
    endtask

    task automatic test_gap_pattern();
        logic pat[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive_cycle(pat[i], 8'($urandom), 8'($urandom), 8'($urandom));
            n_checks++;
            if (done_o !== exp_done || grayscale_o !== exp_gray) begin
                n_fail++;
                $display("FAIL gap[%0d]: got done=%b y=%0d expected done=%b y=%0d",
                         i, done_o, grayscale_o, exp_done, exp_gray);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] y4;
        drive_cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        drive_cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        red_i      = 8'($urandom);
        green_i    = 8'($urandom);
        blue_i     = 8'($urandom);
        cam_done_i = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (done_o !== 1'b0 || grayscale_o !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_now: got done=%b y=%0d expected done=0 y=0",
                     done_o, grayscale_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (done_o !== 1'b0 || grayscale_o !== 8'd0) begin
                n_fail++;
                $display("FAIL midreset_hold[%0d]: got done=%b y=%0d expected done=0 y=0",
                         i, done_o, grayscale_o);
            end
        end
        rst = 1'b1;
        model_reset();
        red_i = 8'($urandom);
        green_i = 8'($urandom);
        blue_i = 8'($urandom);
        y4 = ref_luma(int'(red_i), int'(green_i), int'(blue_i));
        drive_cycle(1'b1, red_i, green_i, blue_i);
        n_checks++;
        if (done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL postreset_early: done got %b expected 0", done_o);
        end
        drive_idle();
        n_checks++;
        if (done_o !== 1'b1 || grayscale_o !== y4) begin
            n_fail++;
            $display("FAIL postreset_out: got done=%b y=%0d expected done=1 y=%0d",
                     done_o, grayscale_o, y4);
        end
        drive_idle();
    endtask

    // scoreboard plus behavioural store: each luma written as B,G,R bytes
    task automatic sample_stream(inout int pulses);
        logic [7:0] e;
        if (done_o === 1'b1) begin
            pulses++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL stream_extra: got y=%0d with empty expected queue", grayscale_o);
            end else begin
                e = exp_q.pop_front();
                if (grayscale_o !== e) begin
                    n_fail++;
                    $display("FAIL stream_pixel[%0d]: got %0d expected %0d",
                             pulses - 1, grayscale_o, e);
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (store_addr < NBYTE) store_mem[store_addr] = grayscale_o;
                store_addr++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int wait_cycles;
        int bad;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        pulses     = 0;
        store_addr = 0;
        bad        = 0;
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) begin
            r = 8'($urandom);
            g = 8'($urandom);
            b = 8'($urandom);
            exp_all[i] = ref_luma(int'(r), int'(g), int'(b));
            exp_q.push_back(exp_all[i]);
            drive_cycle(1'b1, r, g, b);
            sample_stream(pulses);
        end
        wait_cycles = 0;
        while (wait_cycles < 8) begin
            drive_idle();
            sample_stream(pulses);
            wait_cycles++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stream_drain: got %0d pixels still pending expected 0", exp_q.size());
        end
        n_checks++;
        if (pulses != NPIX) begin
            n_fail++;
            $display("FAIL stream_pulses: got %0d expected %0d", pulses, NPIX);
        end
        n_checks++;
        if (store_addr != NBYTE) begin
            n_fail++;
            $display("FAIL store_bytes: got %0d expected %0d", store_addr, NBYTE);
        end
        for (int i = 0; i < NPIX; i++) begin
            n_checks++;
            if (store_mem[3*i] !== exp_all[i] || store_mem[3*i+1] !== exp_all[i] ||
                store_mem[3*i+2] !== exp_all[i]) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL store_pixel[%0d]: got %0d,%0d,%0d expected %0d x3", i,
                             store_mem[3*i], store_mem[3*i+1], store_mem[3*i+2], exp_all[i]);
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        red_i      = 8'd0;
        green_i    = 8'd0;
        blue_i     = 8'd0;
        cam_done_i = 1'b0;
        for (int i = 0; i < NBYTE; i++) store_mem[i] = 8'd0;
        @(negedge clk);
        test_reset();
        test_single_pixels();
        test_gap_pattern();
        test_reset_midstream();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
